// File: rtl/i2s_stream_codec_if.sv
// i2s_stream_codec_if: the two host-side AXI-Stream channels of the I2S bridge.
//   from_host_* carries playback frames {left, right} into the codec bridge.
//   to_host_*   carries recorded frames {left, right} back to the host.
// The master modport is the host/DMA side; the slave modport is the bridge.
interface i2s_stream_codec_if #(
  parameter int SAMPLE_W = 16
);

  logic [2*SAMPLE_W-1:0] from_host_audio_tdata;
  logic                  from_host_audio_tvalid;
  logic                  from_host_audio_tready;

  logic [2*SAMPLE_W-1:0] to_host_audio_tdata;
  logic                  to_host_audio_tvalid;
  logic                  to_host_audio_tready;

  modport master (
    output from_host_audio_tdata,
    output from_host_audio_tvalid,
    input  from_host_audio_tready,
    input  to_host_audio_tdata,
    input  to_host_audio_tvalid,
    output to_host_audio_tready
  );

  modport slave (
    input  from_host_audio_tdata,
    input  from_host_audio_tvalid,
    output from_host_audio_tready,
    output to_host_audio_tdata,
    output to_host_audio_tvalid,
    input  to_host_audio_tready
  );

endinterface

// File: rtl/i2s_stream_codec.sv
// i2s_stream_codec: bridge between AXI-Stream host channels and an external
// I2S codec that masters BCLK/LRCLK. Whole stereo frames are buffered in a
// playback FIFO and a record FIFO; underruns and overruns are counted.
//
// Optional build macro I2S_STREAM_CODEC_LOOPBACK_EN adds a 'loopback' input.
// When it is latched high (at a left-slot start), completed record frames are
// pushed into the playback FIFO instead of the record FIFO, the host playback
// input is held off and the host record output stays idle.
module i2s_stream_codec #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MCLK_DIV   = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  output logic        audio_mclk,
  input  logic        audio_bclk,
  input  logic        audio_lrclk,
  input  logic        audio_adc,
  output logic        audio_dac,
`ifdef I2S_STREAM_CODEC_LOOPBACK_EN
  input  logic        loopback,
`endif
  output logic [15:0] underrun_count,
  output logic [15:0] overrun_count,
  i2s_stream_codec_if.slave axis
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = AW + 1;
  localparam int CNT_W   = $clog2(SAMPLE_W + 1);
  localparam int HALF    = MCLK_DIV / 2;
  localparam int MCNT_W  = (HALF > 1) ? $clog2(HALF) : 1;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [MCNT_W-1:0]   mclkCnt_q;
  logic                mclk_q;

  logic [2:0]          bclkSync_q;
  logic [1:0]          lrclkSync_q;
  logic [1:0]          adcSync_q;
  logic                lrclkPrev_q;
  logic                bclkRise;
  logic                bclkFall;
  logic                lrclkNow;
  logic                adcNow;
  logic                leftStart;
  logic                rightStart;

  logic                run_q;
  logic                loopActive;

  logic [FRAME_W-1:0]  pbMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    pbWr_q, pbWr_d;
  logic [PTR_W-1:0]    pbRd_q, pbRd_d;
  logic                pbFull, pbEmpty;
  logic                pbHostPush, pbLoopPush, pbPush, pbPop;
  logic [FRAME_W-1:0]  pbPushData;
  logic [FRAME_W-1:0]  pbFetch;

  logic [SAMPLE_W-1:0] holdRight_q;
  logic [SAMPLE_W-1:0] dacShift_q;
  logic                dac_q;

  logic [CNT_W-1:0]    bitCnt_q;
  logic                recSlot_q;
  logic                frameOk_q;
  logic [SAMPLE_W-2:0] recShift_q;
  logic [SAMPLE_W-1:0] recShiftNext;
  logic [SAMPLE_W-1:0] recLeft_q;
  logic                recBitStep;
  logic                recDone;
  logic                recRightDone;
  logic [FRAME_W-1:0]  recFrame;

  logic [FRAME_W-1:0]  recMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    recWr_q, recWr_d;
  logic [PTR_W-1:0]    recRd_q, recRd_d;
  logic                recFull, recEmpty;
  logic                recPushReq, recPush, recPop;

  logic [15:0]         underrun_q, underrun_d;
  logic [15:0]         overrun_q, overrun_d;
  logic                underrunEvent, overrunEvent;

  // ---------------------------------------------------------------------------
  // Codec master clock
  // ---------------------------------------------------------------------------

  // Free-running divider: toggle MCLK every MCLK_DIV/2 ap_clk cycles.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      mclkCnt_q <= '0;
      mclk_q    <= 1'b0;
    end else if (mclkCnt_q == MCNT_W'(HALF - 1)) begin
      mclkCnt_q <= '0;
      mclk_q    <= ~mclk_q;
    end else begin
      mclkCnt_q <= mclkCnt_q + MCNT_W'(1);
    end
  end

  assign audio_mclk = mclk_q;

  // ---------------------------------------------------------------------------
  // Input synchronisers and I2S slot detection
  // ---------------------------------------------------------------------------

  // Two flops per asynchronous codec pin; a third bclk stage feeds edge detect.
  // lrclkPrev is the word select seen at the previous BCLK rise.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      bclkSync_q  <= '0;
      lrclkSync_q <= '0;
      adcSync_q   <= '0;
      lrclkPrev_q <= 1'b0;
    end else begin
      bclkSync_q  <= {bclkSync_q[1:0], audio_bclk};
      lrclkSync_q <= {lrclkSync_q[0], audio_lrclk};
      adcSync_q   <= {adcSync_q[0], audio_adc};
      if (bclkRise) begin
        lrclkPrev_q <= lrclkNow;
      end
    end
  end

  // After reset a high BCLK may look like one rise; since lrclkPrev resets to
  // 0 that can only produce a right start, which never pushes (frameOk is 0).
  assign bclkRise   = bclkSync_q[1] & ~bclkSync_q[2];
  assign bclkFall   = ~bclkSync_q[1] & bclkSync_q[2];
  assign lrclkNow   = lrclkSync_q[1];
  assign adcNow     = adcSync_q[1];
  assign leftStart  = bclkRise & ~lrclkNow & lrclkPrev_q;
  assign rightStart = bclkRise & lrclkNow & ~lrclkPrev_q;

  // Marks the first cycle after reset release so host ready stays low in reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

`ifdef I2S_STREAM_CODEC_LOOPBACK_EN
  logic loopActive_q;

  // Loopback mode only changes at a frame boundary so frames are never split.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      loopActive_q <= 1'b0;
    end else if (leftStart) begin
      loopActive_q <= loopback;
    end
  end

  assign loopActive = loopActive_q;
`else
  assign loopActive = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Record capture
  // ---------------------------------------------------------------------------
  assign recShiftNext = {recShift_q, adcNow};
  assign recBitStep   = bclkRise & ~leftStart & ~rightStart & (bitCnt_q != '0);
  assign recDone      = recBitStep & (bitCnt_q == CNT_W'(1));
  assign recRightDone = recDone & recSlot_q & frameOk_q;
  assign recFrame     = {recLeft_q, recShiftNext};

  // Shift ADC bits MSB-first after each slot start; a complete left slot arms
  // frameOk, a slot cut short by LRCLK disarms it so the frame is discarded.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      bitCnt_q   <= '0;
      recSlot_q  <= 1'b0;
      frameOk_q  <= 1'b0;
      recShift_q <= '0;
      recLeft_q  <= '0;
    end else if (leftStart || rightStart) begin
      bitCnt_q  <= CNT_W'(SAMPLE_W);
      recSlot_q <= rightStart;
      if (leftStart || (bitCnt_q != '0)) begin
        frameOk_q <= 1'b0;
      end
    end else if (recBitStep) begin
      recShift_q <= recShiftNext[SAMPLE_W-2:0];
      bitCnt_q   <= bitCnt_q - CNT_W'(1);
      if (recDone && !recSlot_q) begin
        recLeft_q <= recShiftNext;
        frameOk_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Record FIFO (towards host)
  // ---------------------------------------------------------------------------
  assign recFull    = (recWr_q[AW-1:0] == recRd_q[AW-1:0]) && (recWr_q[AW] != recRd_q[AW]);
  assign recEmpty   = (recWr_q == recRd_q);
  assign recPop     = axis.to_host_audio_tvalid & axis.to_host_audio_tready;
  assign recPushReq = recRightDone & ~loopActive;
  assign recPush    = recPushReq & (~recFull | recPop);

  assign axis.to_host_audio_tvalid = ~recEmpty & ~loopActive;
  assign axis.to_host_audio_tdata  = axis.to_host_audio_tvalid ? recMem_q[recRd_q[AW-1:0]] : '0;

  // Record FIFO pointer next-state.
  always_comb begin
    recWr_d = recWr_q;
    recRd_d = recRd_q;
    if (recPush) begin
      recWr_d = recWr_q + PTR_W'(1);
    end
    if (recPop) begin
      recRd_d = recRd_q + PTR_W'(1);
    end
  end

  // Record FIFO pointers; reset flushes the buffer.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      recWr_q <= '0;
      recRd_q <= '0;
    end else begin
      recWr_q <= recWr_d;
      recRd_q <= recRd_d;
    end
  end

  // Record FIFO storage.
  always_ff @(posedge ap_clk) begin
    if (recPush) begin
      recMem_q[recWr_q[AW-1:0]] <= recFrame;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FIFO (from host, or from record path in loopback)
  // ---------------------------------------------------------------------------
  assign pbFull     = (pbWr_q[AW-1:0] == pbRd_q[AW-1:0]) && (pbWr_q[AW] != pbRd_q[AW]);
  assign pbEmpty    = (pbWr_q == pbRd_q);
  assign pbPop      = leftStart & ~pbEmpty;
  assign pbHostPush = axis.from_host_audio_tvalid & axis.from_host_audio_tready;
  assign pbLoopPush = recRightDone & loopActive;
  assign pbPush     = pbHostPush | (pbLoopPush & (~pbFull | pbPop));
  assign pbPushData = loopActive ? recFrame : axis.from_host_audio_tdata;
  assign pbFetch    = pbEmpty ? '0 : pbMem_q[pbRd_q[AW-1:0]];

  assign axis.from_host_audio_tready = run_q & ~pbFull & ~loopActive;

  // Playback FIFO pointer next-state.
  always_comb begin
    pbWr_d = pbWr_q;
    pbRd_d = pbRd_q;
    if (pbPush) begin
      pbWr_d = pbWr_q + PTR_W'(1);
    end
    if (pbPop) begin
      pbRd_d = pbRd_q + PTR_W'(1);
    end
  end

  // Playback FIFO pointers; reset flushes the buffer.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      pbWr_q <= '0;
      pbRd_q <= '0;
    end else begin
      pbWr_q <= pbWr_d;
      pbRd_q <= pbRd_d;
    end
  end

  // Playback FIFO storage.
  always_ff @(posedge ap_clk) begin
    if (pbPush) begin
      pbMem_q[pbWr_q[AW-1:0]] <= pbPushData;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback serialiser
  // ---------------------------------------------------------------------------

  // Fetch a frame at each left start (zeros if starved), load the slot's
  // sample at each slot start, and drive one bit per BCLK fall so the MSB
  // lands one bit after the LRCLK transition; trailing slot bits are zero.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      holdRight_q <= '0;
      dacShift_q  <= '0;
      dac_q       <= 1'b0;
    end else if (leftStart) begin
      holdRight_q <= pbFetch[SAMPLE_W-1:0];
      dacShift_q  <= pbFetch[FRAME_W-1:SAMPLE_W];
    end else if (rightStart) begin
      dacShift_q <= holdRight_q;
    end else if (bclkFall) begin
      dac_q      <= dacShift_q[SAMPLE_W-1];
      dacShift_q <= {dacShift_q[SAMPLE_W-2:0], 1'b0};
    end
  end

  assign audio_dac = dac_q;

  // ---------------------------------------------------------------------------
  // Saturating error counters
  // ---------------------------------------------------------------------------
  assign underrunEvent = leftStart & pbEmpty;
  assign overrunEvent  = (recPushReq & recFull & ~recPop) |
                         (pbLoopPush & pbFull & ~pbPop);

  // Counter next-state with saturation at all-ones.
  always_comb begin
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    if (underrunEvent && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
    if (overrunEvent && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      underrun_q <= '0;
      overrun_q  <= '0;
    end else begin
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign underrun_count = underrun_q;
  assign overrun_count  = overrun_q;

endmodule
